prbs_burst_sequencer: RTL and testbench

Controller that sequences the PRBS pattern generator feeding the DAC datapath on the memristor testboard.
- Takes a burst configuration from the AXI4-Lite register block.
- Loads the generator seed, then gates generator stepping against DAC-side AXI-Stream backpressure.
- Inserts programmable idle gaps between bursts, counts repeats and reports status back to the registers.
- Sits between the register slave, the PRBS generator core and the DAC stream interface.

---
 rtl/prbs_ctrl_pkg.sv | 24 ++
 rtl/prbs_burst_sequencer_if.sv | 26 ++
 rtl/prbs_seq_counter.sv | 39 +++
 rtl/prbs_burst_sequencer.sv | 145 ++++++++++++++
 tb/tb_prbs_burst_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared types and default widths for the PRBS burst sequencer.
// Included by the sequencer, its counter, its interface and the bench.
package prbs_ctrl_pkg;

  localparam int PRBS_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  // Burst configuration at default widths; "repeat" is a keyword, hence repeat_n.
  typedef struct packed {
    logic [PRBS_W_DEF-1:0] seed;
    logic [CNT_W_DEF-1:0]  burst_len;
    logic [CNT_W_DEF-1:0]  gap;
    logic [CNT_W_DEF-1:0]  repeat_n;
  } prbs_cfg_t;

endpackage

// File: rtl/prbs_burst_sequencer_if.sv
// Generator control and DAC AXI-Stream signals of the burst sequencer.
// The master side is the sequencer; the slave side is the generator/DAC.
interface prbs_burst_sequencer_if
  import prbs_ctrl_pkg::*;
#(
  parameter int PRBS_W = PRBS_W_DEF
);

  logic              gen_load;
  logic [PRBS_W-1:0] gen_seed;
  logic              gen_step;
  logic              dac_tvalid;
  logic              dac_tready;
  logic              dac_tlast;

  modport master (
    output gen_load, gen_seed, gen_step, dac_tvalid, dac_tlast,
    input  dac_tready
  );

  modport slave (
    input  gen_load, gen_seed, gen_step, dac_tvalid, dac_tlast,
    output dac_tready
  );

endinterface

// File: rtl/prbs_seq_counter.sv
// Loadable up-counter with a terminal-count flag (count == limit).
// Load has priority over increment.
module prbs_seq_counter
  import prbs_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/prbs_burst_sequencer.sv
// Sequences seed load, backpressured generator stepping, inter-burst gaps
// and repeat counting for the PRBS generator feeding the DAC stream.
module prbs_burst_sequencer
  import prbs_ctrl_pkg::*;
#(
  parameter int PRBS_W      = PRBS_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit RESEED_EACH = 1'b0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [PRBS_W-1:0]     cfg_seed,
  input  logic [CNT_W-1:0]      cfg_burst_len,
  input  logic [CNT_W-1:0]      cfg_gap,
  input  logic [CNT_W-1:0]      cfg_repeat,
  prbs_burst_sequencer_if.master dac,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      burst_cnt
);

  typedef struct packed {
    logic [PRBS_W-1:0] seed;
    logic [CNT_W-1:0]  burst_len;
    logic [CNT_W-1:0]  gap;
    logic [CNT_W-1:0]  repeat_n;
  } seq_cfg_t;

  seq_state_t       state_q, state_d;
  seq_cfg_t         cfg_q, cfg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_cnt_inc;
  logic [CNT_W-1:0] word_limit, gap_limit;
  logic             tvalid, hs;
  logic             word_load, word_last;
  logic             gap_load, gap_en, gap_last;

  assign tvalid     = (state_q == ST_RUN);
  assign hs         = tvalid & dac.dac_tready;
  assign word_limit = cfg_q.burst_len - CNT_W'(1);
  assign gap_limit  = cfg_q.gap - CNT_W'(1);

  // Word counter restarts on every last-word handshake so back-to-back bursts need no bubble.
  assign word_load = (state_q != ST_RUN) | (hs & word_last);
  assign gap_load  = (state_q != ST_GAP);
  assign gap_en    = (state_q == ST_GAP);

  prbs_seq_counter #(.W(CNT_W)) u_word_cnt (
    .clk      (ACLK),
    .srst     (ARESET),
    .load     (word_load),
    .load_val ('0),
    .en       (hs),
    .limit    (word_limit),
    .tc       (word_last)
  );

  prbs_seq_counter #(.W(CNT_W)) u_gap_cnt (
    .clk      (ACLK),
    .srst     (ARESET),
    .load     (gap_load),
    .load_val ('0),
    .en       (gap_en),
    .limit    (gap_limit),
    .tc       (gap_last)
  );

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    err_d         = err_q;
    burst_cnt_d   = burst_cnt_q;
    burst_cnt_inc = burst_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          cfg_d.seed      = cfg_seed;
          cfg_d.burst_len = cfg_burst_len;
          cfg_d.gap       = cfg_gap;
          cfg_d.repeat_n  = cfg_repeat;
          if (cfg_burst_len == '0) begin
            err_d = 1'b1;
          end else begin
            err_d       = 1'b0;
            burst_cnt_d = '0;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (hs && word_last) begin
          burst_cnt_d = burst_cnt_inc;
          if ((cfg_q.repeat_n != '0) && (burst_cnt_inc == cfg_q.repeat_n)) begin
            state_d = ST_DONE;
          end else if (cfg_q.gap != '0) begin
            state_d = ST_GAP;
          end else if (RESEED_EACH) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_d = RESEED_EACH ? ST_LOAD : ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every transition, but a handshake in the same cycle still counts.
    if (cfg_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      err_q       <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      err_q       <= err_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign dac.gen_load   = (state_q == ST_LOAD);
  assign dac.gen_seed   = (state_q == ST_LOAD) ? cfg_q.seed : '0;
  assign dac.gen_step   = hs;
  assign dac.dac_tvalid = tvalid;
  assign dac.dac_tlast  = tvalid & word_last;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign burst_cnt      = burst_cnt_q;

endmodule

// File: tb/tb_prbs_burst_sequencer.sv
// Directed bench: two sequencers (RESEED_EACH = 0 and 1) share stimulus and
// are compared cycle by cycle against hand-computed per-cycle bit masks.
module tb_prbs_burst_sequencer;
  import prbs_ctrl_pkg::*;

  localparam int PW = PRBS_W_DEF;
  localparam int CW = CNT_W_DEF;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cfg_start;
  logic          cfg_abort;
  logic [PW-1:0] cfg_seed;
  logic [CW-1:0] cfg_burst_len;
  logic [CW-1:0] cfg_gap;
  logic [CW-1:0] cfg_repeat;
  logic          tready;
  logic          busy0, done0, err0;
  logic          busy1, done1, err1;
  logic [CW-1:0] bcnt0, bcnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int bp_pat [5] = '{1, 0, 0, 1, 1};

  prbs_burst_sequencer_if #(.PRBS_W(PW)) if0 ();
  prbs_burst_sequencer_if #(.PRBS_W(PW)) if1 ();

  assign if0.dac_tready = tready;
  assign if1.dac_tready = tready;

  always #5 ACLK = ~ACLK;

  prbs_burst_sequencer #(.PRBS_W(PW), .CNT_W(CW), .RESEED_EACH(1'b0)) u_dut0 (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_seed      (cfg_seed),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .cfg_repeat    (cfg_repeat),
    .dac           (if0),
    .busy          (busy0),
    .done          (done0),
    .err           (err0),
    .burst_cnt     (bcnt0)
  );

  prbs_burst_sequencer #(.PRBS_W(PW), .CNT_W(CW), .RESEED_EACH(1'b1)) u_dut1 (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_seed      (cfg_seed),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .cfg_repeat    (cfg_repeat),
    .dac           (if1),
    .busy          (busy1),
    .done          (done1),
    .err           (err1),
    .burst_cnt     (bcnt1)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Issues start in the current cycle; returns in cycle 1 with cfg_* scrambled
  // so that any leak of live config into the run shows up.
  task automatic start_run(input logic [PW-1:0] seed, input logic [CW-1:0] len,
                           input logic [CW-1:0] gap, input logic [CW-1:0] rep);
    cfg_seed      = seed;
    cfg_burst_len = len;
    cfg_gap       = gap;
    cfg_repeat    = rep;
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
    cfg_seed      = 32'hDEAD_BEEF;
    cfg_burst_len = 16'd9;
    cfg_gap       = 16'd7;
    cfg_repeat    = 16'd5;
  endtask

  // Bit c of each mask is the expected value in cycle c (start was cycle 0); tready held at 1.
  task automatic run_case(input string name, input int ncyc,
                          input logic [15:0] tv0, input logic [15:0] tv1,
                          input logic [15:0] ld0, input logic [15:0] ld1,
                          input logic [15:0] tl0, input logic [15:0] tl1,
                          input logic [15:0] dn0, input logic [15:0] dn1);
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) step();
      #1;
      check($sformatf("%s c%0d tvalid0", name, c), 64'(if0.dac_tvalid), 64'(tv0[c]));
      check($sformatf("%s c%0d tvalid1", name, c), 64'(if1.dac_tvalid), 64'(tv1[c]));
      check($sformatf("%s c%0d step0", name, c),   64'(if0.gen_step),   64'(tv0[c]));
      check($sformatf("%s c%0d step1", name, c),   64'(if1.gen_step),   64'(tv1[c]));
      check($sformatf("%s c%0d load0", name, c),   64'(if0.gen_load),   64'(ld0[c]));
      check($sformatf("%s c%0d load1", name, c),   64'(if1.gen_load),   64'(ld1[c]));
      check($sformatf("%s c%0d tlast0", name, c),  64'(if0.dac_tlast),  64'(tl0[c]));
      check($sformatf("%s c%0d tlast1", name, c),  64'(if1.dac_tlast),  64'(tl1[c]));
      check($sformatf("%s c%0d done0", name, c),   64'(done0),          64'(dn0[c]));
      check($sformatf("%s c%0d done1", name, c),   64'(done1),          64'(dn1[c]));
    end
    $display("case %s: %0d cycles compared", name, ncyc);
  endtask

  initial begin
    int steps0, steps1, lasts, dones, guard;
    logic seen;

    ARESET        = 1'b1;
    cfg_start     = 1'b0;
    cfg_abort     = 1'b0;
    cfg_seed      = '0;
    cfg_burst_len = '0;
    cfg_gap       = '0;
    cfg_repeat    = '0;
    tready        = 1'b1;
    step();
    step();
    check("rst busy",   64'(busy1),          64'd0);
    check("rst tvalid", 64'(if1.dac_tvalid), 64'd0);
    check("rst load",   64'(if1.gen_load),   64'd0);
    check("rst seed",   64'(if1.gen_seed),   64'd0);
    check("rst err",    64'(err1),           64'd0);
    check("rst bcnt",   64'(bcnt1),          64'd0);
    ARESET = 1'b0;
    step();
    $display("case reset: outputs compared");

    // Basic run: load at 1, valid 2..5, last at 5, done at 6.
    start_run(32'h0000_ACE1, 16'd4, 16'd0, 16'd1);
    #1;
    check("basic seed0", 64'(if0.gen_seed), 64'h0000_ACE1);
    check("basic seed1", 64'(if1.gen_seed), 64'h0000_ACE1);
    check("basic busy1", 64'(busy1), 64'd1);
    run_case("basic", 7, 16'h003C, 16'h003C, 16'h0002, 16'h0002,
             16'h0020, 16'h0020, 16'h0040, 16'h0040);
    check("basic bcnt0", 64'(bcnt0), 64'd1);
    check("basic bcnt1", 64'(bcnt1), 64'd1);
    check("basic idle",  64'(busy1), 64'd0);

    // Backpressure: tready 1,0,0,1,1 over cycles 2..6, len=3.
    start_run(32'h0000_0F0F, 16'd3, 16'd0, 16'd1);
    steps0 = 0;
    steps1 = 0;
    for (int c = 2; c <= 7; c++) begin
      step();
      tready = (c <= 6) ? bp_pat[c-2][0] : 1'b1;
      #1;
      if (if0.gen_step) steps0++;
      if (if1.gen_step) steps1++;
      check($sformatf("bp c%0d tvalid1", c), 64'(if1.dac_tvalid), 64'(c <= 6));
      check($sformatf("bp c%0d tlast1", c),  64'(if1.dac_tlast),  64'(c == 6));
      check($sformatf("bp c%0d done0", c),   64'(done0),          64'(c == 7));
    end
    tready = 1'b1;
    check("bp steps0", 64'(steps0), 64'd3);
    check("bp steps1", 64'(steps1), 64'd3);
    $display("case backpressure: %0d/%0d steps", steps0, steps1);
    step();

    // Gap=3, repeat=2: reseeding copy reloads after the gap, the other resumes RUN.
    start_run(32'h0000_1357, 16'd2, 16'd3, 16'd2);
    run_case("gap", 11, 16'h018C, 16'h030C, 16'h0002, 16'h0082,
             16'h0108, 16'h0208, 16'h0200, 16'h0400);
    check("gap bcnt0", 64'(bcnt0), 64'd2);
    check("gap bcnt1", 64'(bcnt1), 64'd2);

    // Gap=0, repeat=2: no bubble without reseed; reseed inserts a LOAD.
    start_run(32'h0000_2468, 16'd2, 16'd0, 16'd2);
    run_case("nogap", 8, 16'h003C, 16'h006C, 16'h0002, 16'h0012,
             16'h0028, 16'h0048, 16'h0040, 16'h0080);

    // Illegal length sets err without leaving IDLE; a valid start clears it.
    start_run(32'h0000_0055, 16'd0, 16'd0, 16'd1);
    check("ill err0",  64'(err0),  64'd1);
    check("ill err1",  64'(err1),  64'd1);
    check("ill busy1", 64'(busy1), 64'd0);
    step();
    check("ill done1", 64'(done1), 64'd0);
    check("ill busy1b", 64'(busy1), 64'd0);
    start_run(32'h0000_0077, 16'd1, 16'd0, 16'd1);
    check("ill clr err1", 64'(err1),  64'd0);
    check("ill run busy1", 64'(busy1), 64'd1);
    step();
    step();
    check("ill run done1", 64'(done1), 64'd1);
    step();
    $display("case illegal: err set and cleared");

    // Abort at cycle 7: dut1 is on word 1 of burst 2, dut0 on the last word of burst 2.
    start_run(32'h0000_0ABC, 16'd3, 16'd0, 16'd0);
    dones = 0;
    for (int c = 2; c <= 9; c++) begin
      step();
      cfg_abort = (c == 7);
      #1;
      if (done0 || done1) dones++;
      if (c == 7) begin
        check("abort step0", 64'(if0.gen_step), 64'd1);
        check("abort step1", 64'(if1.gen_step), 64'd1);
      end
      if (c == 8) begin
        check("abort tvalid0", 64'(if0.dac_tvalid), 64'd0);
        check("abort tvalid1", 64'(if1.dac_tvalid), 64'd0);
        check("abort busy1",   64'(busy1), 64'd0);
        check("abort bcnt0",   64'(bcnt0), 64'd2);
        check("abort bcnt1",   64'(bcnt1), 64'd1);
      end
    end
    cfg_abort = 1'b0;
    check("abort no done", 64'(dones), 64'd0);
    $display("case abort: done pulses %0d", dones);

    // Abort coinciding with the completing handshake wins over DONE.
    start_run(32'h0000_0001, 16'd1, 16'd0, 16'd1);
    step();
    cfg_abort = 1'b1;
    #1;
    check("abtc step1", 64'(if1.gen_step), 64'd1);
    step();
    cfg_abort = 1'b0;
    check("abtc done0", 64'(done0), 64'd0);
    check("abtc done1", 64'(done1), 64'd0);
    check("abtc busy0", 64'(busy0), 64'd0);
    check("abtc bcnt1", 64'(bcnt1), 64'd1);
    step();
    check("abtc done1b", 64'(done1), 64'd0);
    $display("case abort-vs-complete compared");

    // Reset while in GAP, then a fresh run.
    start_run(32'h0000_4321, 16'd2, 16'd5, 16'd2);
    for (int c = 2; c <= 5; c++) step();
    check("rstm gap busy1", 64'(busy1), 64'd1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("rstm busy0",  64'(busy0),          64'd0);
    check("rstm busy1",  64'(busy1),          64'd0);
    check("rstm bcnt0",  64'(bcnt0),          64'd0);
    check("rstm bcnt1",  64'(bcnt1),          64'd0);
    check("rstm tvalid", 64'(if1.dac_tvalid), 64'd0);
    check("rstm load",   64'(if1.gen_load),   64'd0);
    check("rstm done",   64'(done1),          64'd0);
    start_run(32'h0000_1234, 16'd1, 16'd0, 16'd1);
    check("rstm2 load1", 64'(if1.gen_load), 64'd1);
    check("rstm2 seed1", 64'(if1.gen_seed), 64'h0000_1234);
    step();
    check("rstm2 tlast1", 64'(if1.dac_tlast), 64'd1);
    step();
    check("rstm2 done1", 64'(done1), 64'd1);
    check("rstm2 bcnt1", 64'(bcnt1), 64'd1);
    step();
    $display("case reset-mid-run compared");

    // Maximum burst length must give exactly 65535 words and one tlast.
    start_run(32'h0000_0001, 16'hFFFF, 16'd0, 16'd1);
    steps0 = 0;
    steps1 = 0;
    lasts  = 0;
    seen   = 1'b0;
    guard  = 0;
    while (!seen && guard < 70000) begin
      if (if0.gen_step)  steps0++;
      if (if1.gen_step)  steps1++;
      if (if1.dac_tlast) lasts++;
      if (done1) begin
        seen = 1'b1;
      end else begin
        step();
        guard++;
      end
    end
    check("max done seen", 64'(seen),   64'd1);
    check("max steps0",    64'(steps0), 64'd65535);
    check("max steps1",    64'(steps1), 64'd65535);
    check("max tlast",     64'(lasts),  64'd1);
    $display("case maxlen: %0d words", steps1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
